// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types and opcodes for a 32-bit data bus.
package tlul_pkg;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [7:0]  a_user;
      logic        d_ready;
   } tlul_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [7:0]  d_user;
      logic        d_error;
      logic        a_ready;
   } tlul_d2h_t;

endpackage

// File: rtl/tlul_err.sv
// Legality check of a TL-UL A-channel request: opcode, size, alignment and mask.
module tlul_err
   import tlul_pkg::*;
(
   input  logic [2:0] opcode,
   input  logic [1:0] size,
   input  logic [1:0] addr,
   input  logic [3:0] mask,
   output logic       err_o
);

   logic [3:0] lane;
   logic       op_ok, addr_ok, mask_ok, full_ok;

   assign lane  = 4'b0001 << addr;
   assign op_ok = (opcode == Get) || (opcode == PutFullData) || (opcode == PutPartialData);

   always_comb begin
      addr_ok = 1'b0;
      mask_ok = 1'b0;
      full_ok = 1'b0;
      case (size)
         2'd0: begin
            addr_ok = 1'b1;
            mask_ok = ~|(mask & ~lane);
            full_ok = |(mask & lane);
         end
         2'd1: begin
            addr_ok = ~addr[0];
            mask_ok = addr[1] ? ~|mask[1:0] : ~|mask[3:2];
            full_ok = addr[1] ? &mask[3:2] : &mask[1:0];
         end
         2'd2: begin
            addr_ok = (addr == 2'd0);
            mask_ok = 1'b1;
            full_ok = &mask;
         end
         default: ;
      endcase
   end

   // A full write must enable every byte lane it covers; other opcodes skip that test.
   assign err_o = ~(op_ok & addr_ok & mask_ok & ((opcode != PutFullData) | full_ok));

endmodule

// File: rtl/tlul_err_gate.sv
// TL-UL filter: forwards legal host requests to the device, answers illegal ones
// with an in-order error response once all earlier device transactions have drained.
module tlul_err_gate
   import tlul_pkg::*;
#(
   parameter int          MaxOutstanding = 4,
   parameter logic [31:0] ErrData        = 32'hFFFF_FFFF
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  tlul_h2d_t tl_h_i,
   output tlul_d2h_t tl_h_o,
   output tlul_h2d_t tl_d_o,
   input  tlul_d2h_t tl_d_i
);

   localparam int CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, ERR_RESP} state_t;

   state_t          state;
   logic [CntW-1:0] cnt;
   logic [2:0]      op_q;
   logic [1:0]      size_q;
   logic [7:0]      source_q;
   logic            err_raw, err, cnt_ok, inc, dec;

   tlul_err u_err (
      .opcode (tl_h_i.a_opcode),
      .size   (tl_h_i.a_size),
      .addr   (tl_h_i.a_address[1:0]),
      .mask   (tl_h_i.a_mask),
      .err_o  (err_raw)
   );

   assign err    = tl_h_i.a_valid & err_raw;
   assign cnt_ok = cnt < CntW'(MaxOutstanding);

   always_comb begin
      tl_d_o         = tl_h_i;
      tl_d_o.a_valid = 1'b0;
      tl_h_o         = tl_d_i;
      tl_h_o.a_ready = 1'b0;
      case (state)
         IDLE: begin
            // Illegal requests are sunk immediately, even with the device window full.
            if (err) begin
               tl_h_o.a_ready = 1'b1;
            end else begin
               tl_d_o.a_valid = tl_h_i.a_valid & cnt_ok;
               tl_h_o.a_ready = tl_d_i.a_ready & cnt_ok;
            end
         end
         ERR_RESP: begin
            tl_h_o.d_valid  = 1'b1;
            tl_h_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
            tl_h_o.d_param  = 3'd0;
            tl_h_o.d_size   = size_q;
            tl_h_o.d_source = source_q;
            tl_h_o.d_sink   = 1'b0;
            tl_h_o.d_data   = ErrData;
            tl_h_o.d_user   = '0;
            tl_h_o.d_error  = 1'b1;
            tl_d_o.d_ready  = 1'b0;
         end
         default: ;
      endcase
   end

   assign inc = tl_d_o.a_valid & tl_d_i.a_ready;
   assign dec = tl_d_i.d_valid & tl_d_o.d_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         op_q     <= '0;
         size_q   <= '0;
         source_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (err) begin
                  op_q     <= tl_h_i.a_opcode;
                  size_q   <= tl_h_i.a_size;
                  source_q <= tl_h_i.a_source;
                  state    <= DRAIN;
               end
            end
            DRAIN:    if (cnt == '0) state <= ERR_RESP;
            ERR_RESP: if (tl_h_i.d_ready) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Clamped at both ends so a misbehaving device cannot wrap the count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (inc && !dec && cnt_ok) begin
         cnt <= cnt + CntW'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - CntW'(1);
      end
   end

   a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inc && !dec) |-> cnt_ok);
   a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (dec && !inc) |-> (cnt != '0));
   a_err_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state == ERR_RESP && !tl_h_i.d_ready) |=>
      (state == ERR_RESP && $stable({op_q, size_q, source_q})));
   a_fwd_idle_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state != IDLE) |-> !tl_d_o.a_valid);

endmodule

// File: tb/tb_tlul_err_gate.sv
// Directed bench for tlul_err_gate: legality table plus ordering, backpressure and reset sequences.
module tb_tlul_err_gate;
   import tlul_pkg::*;

   logic      clk;
   logic      rst_n;
   tlul_h2d_t h_i, d_o;
   tlul_d2h_t h_o, d_i;

   int n_tests = 0;
   int n_fail  = 0;

   tlul_err_gate #(.MaxOutstanding(4), .ErrData(32'hFFFF_FFFF)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tl_h_i (h_i),
      .tl_h_o (h_o),
      .tl_d_o (d_o),
      .tl_d_i (d_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [7:0]  src;
      logic        legal;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [7:0] src);
      h_i.a_valid   = 1'b1;
      h_i.a_opcode  = op;
      h_i.a_size    = size;
      h_i.a_address = addr;
      h_i.a_mask    = mask;
      h_i.a_source  = src;
      h_i.a_data    = 32'hA5A5_0000 | {24'd0, src};
   endtask

   task automatic dev_resp(input logic [7:0] src);
      d_i.d_valid  = 1'b1;
      d_i.d_opcode = AccessAckData;
      d_i.d_size   = 2'd2;
      d_i.d_source = src;
      d_i.d_data   = 32'hCAFE_0000 | {24'd0, src};
      d_i.d_error  = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{Get,            2'd2, 32'h100, 4'hF, 8'd1,  1'b1};
      vecs[1]  = '{PutFullData,    2'd2, 32'h102, 4'hF, 8'd2,  1'b0};
      vecs[2]  = '{3'h5,           2'd2, 32'h000, 4'hF, 8'd3,  1'b0};
      vecs[3]  = '{Get,            2'd3, 32'h000, 4'hF, 8'd4,  1'b0};
      vecs[4]  = '{PutFullData,    2'd0, 32'h001, 4'h2, 8'd5,  1'b1};
      vecs[5]  = '{PutFullData,    2'd0, 32'h001, 4'h1, 8'd6,  1'b0};
      vecs[6]  = '{PutPartialData, 2'd2, 32'h004, 4'h5, 8'd7,  1'b1};
      vecs[7]  = '{PutFullData,    2'd2, 32'h000, 4'h7, 8'd8,  1'b0};
      vecs[8]  = '{Get,            2'd1, 32'h002, 4'hC, 8'd9,  1'b1};
      vecs[9]  = '{Get,            2'd1, 32'h001, 4'h3, 8'd10, 1'b0};
      vecs[10] = '{PutFullData,    2'd1, 32'h000, 4'hC, 8'd11, 1'b0};
      vecs[11] = '{Get,            2'd0, 32'h003, 4'h8, 8'd12, 1'b1};

      h_i   = '0;
      d_i   = '0;
      rst_n = 1'b0;

      // Reset state: D channel passes through, nothing forwarded.
      d_i.d_valid = 1'b1;
      #2;
      chk("rst cnt", 64'(dut.cnt), 64'd0);
      chk("rst h d_valid follows", 64'(h_o.d_valid), 64'd1);
      chk("rst d a_valid", 64'(d_o.a_valid), 64'd0);
      d_i = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Legality table, device never ready so legal requests stay pending.
      for (int i = 0; i < 12; i++) begin
         set_req(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].src);
         #1;
         chk($sformatf("vec%0d fwd", i), 64'(d_o.a_valid), 64'(vecs[i].legal));
         chk($sformatf("vec%0d a_ready", i), 64'(h_o.a_ready), 64'(!vecs[i].legal));
         if (vecs[i].legal)
            chk($sformatf("vec%0d addr", i), 64'(d_o.a_address), 64'(vecs[i].addr));
         tick();
         if (!vecs[i].legal) begin
            h_i.a_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d drain d_valid", i), 64'(h_o.d_valid), 64'd0);
            tick();
            chk($sformatf("vec%0d err d_valid", i), 64'(h_o.d_valid), 64'd1);
            chk($sformatf("vec%0d err d_error", i), 64'(h_o.d_error), 64'd1);
            chk($sformatf("vec%0d err src", i), 64'(h_o.d_source), 64'(vecs[i].src));
            chk($sformatf("vec%0d err size", i), 64'(h_o.d_size), 64'(vecs[i].size));
            chk($sformatf("vec%0d err opcode", i), 64'(h_o.d_opcode),
                (vecs[i].op == Get) ? 64'(AccessAckData) : 64'(AccessAck));
            chk($sformatf("vec%0d err data", i), 64'(h_o.d_data), 64'hFFFF_FFFF);
            h_i.d_ready = 1'b1;
            tick();
            h_i.d_ready = 1'b0;
         end
      end
      h_i = '0;
      tick();

      // Legal Get forwarded, response returned, counter 0->1->0.
      set_req(Get, 2'd2, 32'h100, 4'hF, 8'd3);
      d_i.a_ready = 1'b1;
      #1;
      chk("get fwd", 64'(d_o.a_valid), 64'd1);
      chk("get addr", 64'(d_o.a_address), 64'h100);
      chk("get src", 64'(d_o.a_source), 64'd3);
      chk("get a_ready", 64'(h_o.a_ready), 64'd1);
      tick();
      chk("get cnt1", 64'(dut.cnt), 64'd1);
      h_i.a_valid = 1'b0;
      d_i.a_ready = 1'b0;
      dev_resp(8'd3);
      h_i.d_ready = 1'b1;
      #1;
      chk("get resp valid", 64'(h_o.d_valid), 64'd1);
      chk("get resp opcode", 64'(h_o.d_opcode), 64'(AccessAckData));
      chk("get resp src", 64'(h_o.d_source), 64'd3);
      chk("get resp error", 64'(h_o.d_error), 64'd0);
      chk("get resp data", 64'(h_o.d_data), 64'hCAFE_0003);
      chk("get d_ready pass", 64'(d_o.d_ready), 64'd1);
      tick();
      chk("get cnt0", 64'(dut.cnt), 64'd0);
      d_i = '0;
      h_i = '0;
      tick();

      // Three outstanding Gets, then an illegal opcode: error only after all three responses.
      d_i.a_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(Get, 2'd2, 32'h200, 4'hF, 8'(10 + i));
         tick();
      end
      chk("ord cnt3", 64'(dut.cnt), 64'd3);
      set_req(3'h5, 2'd2, 32'h0, 4'hF, 8'd9);
      #1;
      chk("ord illegal accepted", 64'(h_o.a_ready), 64'd1);
      chk("ord illegal not fwd", 64'(d_o.a_valid), 64'd0);
      tick();
      h_i.a_valid = 1'b0;
      h_i.d_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dev_resp(8'(10 + i));
         #1;
         chk($sformatf("ord resp%0d valid", i), 64'(h_o.d_valid), 64'd1);
         chk($sformatf("ord resp%0d src", i), 64'(h_o.d_source), 64'(10 + i));
         chk($sformatf("ord resp%0d error", i), 64'(h_o.d_error), 64'd0);
         chk($sformatf("ord resp%0d a_ready", i), 64'(h_o.a_ready), 64'd0);
         tick();
      end
      d_i.d_valid = 1'b0;
      #1;
      chk("ord drain gap", 64'(h_o.d_valid), 64'd0);
      tick();
      chk("ord err valid", 64'(h_o.d_valid), 64'd1);
      chk("ord err error", 64'(h_o.d_error), 64'd1);
      chk("ord err src", 64'(h_o.d_source), 64'd9);
      chk("ord err opcode", 64'(h_o.d_opcode), 64'(AccessAck));
      tick();
      d_i = '0;
      h_i = '0;
      tick();

      // Window full: fifth request stalls until one response is consumed.
      d_i.a_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(Get, 2'd2, 32'h300, 4'hF, 8'(20 + i));
         #1;
         chk($sformatf("max req%0d a_ready", i), 64'(h_o.a_ready), 64'd1);
         tick();
      end
      chk("max cnt4", 64'(dut.cnt), 64'd4);
      set_req(Get, 2'd2, 32'h300, 4'hF, 8'd24);
      #1;
      chk("max 5th a_ready", 64'(h_o.a_ready), 64'd0);
      chk("max 5th fwd", 64'(d_o.a_valid), 64'd0);
      dev_resp(8'd20);
      h_i.d_ready = 1'b1;
      #1;
      chk("max resp cycle a_ready", 64'(h_o.a_ready), 64'd0);
      tick();
      d_i.d_valid = 1'b0;
      #1;
      chk("max after resp a_ready", 64'(h_o.a_ready), 64'd1);
      chk("max after resp fwd", 64'(d_o.a_valid), 64'd1);
      tick();
      h_i.a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dev_resp(8'(21 + i));
         tick();
      end
      chk("max drained cnt", 64'(dut.cnt), 64'd0);
      d_i = '0;
      h_i = '0;
      tick();

      // Misaligned PutFullData; error response held under host backpressure.
      set_req(PutFullData, 2'd2, 32'h102, 4'hF, 8'd5);
      #1;
      chk("hold accepted", 64'(h_o.a_ready), 64'd1);
      chk("hold not fwd", 64'(d_o.a_valid), 64'd0);
      tick();
      h_i.a_valid = 1'b0;
      tick();
      set_req(Get, 2'd2, 32'h400, 4'hF, 8'd6);
      d_i.a_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("hold%0d valid", i), 64'(h_o.d_valid), 64'd1);
         chk($sformatf("hold%0d fields", i),
             64'({h_o.d_opcode, h_o.d_size, h_o.d_source, h_o.d_error, h_o.d_data}),
             64'({AccessAck, 2'd2, 8'd5, 1'b1, 32'hFFFF_FFFF}));
         chk($sformatf("hold%0d a_ready", i), 64'(h_o.a_ready), 64'd0);
         chk($sformatf("hold%0d d d_ready", i), 64'(d_o.d_ready), 64'd0);
         tick();
      end
      h_i.d_ready = 1'b1;
      tick();
      h_i.d_ready = 1'b0;
      #1;
      chk("hold back idle a_ready", 64'(h_o.a_ready), 64'd1);
      h_i.a_valid = 1'b0;
      d_i = '0;
      tick();

      // Reset while draining with two device transactions outstanding.
      d_i.a_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_req(Get, 2'd2, 32'h500, 4'hF, 8'(30 + i));
         tick();
      end
      set_req(3'h5, 2'd2, 32'h0, 4'hF, 8'd40);
      tick();
      h_i.a_valid = 1'b0;
      #1;
      chk("rstmid drain a_ready", 64'(h_o.a_ready), 64'd0);
      chk("rstmid cnt2", 64'(dut.cnt), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("rstmid cnt0", 64'(dut.cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rstmid idle a_ready", 64'(h_o.a_ready), 64'd1);
      dev_resp(8'd30);
      #1;
      chk("rstmid pass valid", 64'(h_o.d_valid), 64'd1);
      chk("rstmid pass error", 64'(h_o.d_error), 64'd0);
      d_i.d_valid = 1'b0;
      #1;
      chk("rstmid pass low", 64'(h_o.d_valid), 64'd0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
